alu_output_router: RTL and testbench
====================================

# alu_output_router

Parametrised, buffered replacement for the calc1 ALU output stage. Takes the single prioritised ALU result stream, classifies each result into a 2-bit response, and queues response plus data in a per-requester FIFO. Each requester port presents its oldest entry until that requester acknowledges it, so a busy requester no longer loses results. Sits between the ALU/priority logic and the requester output ports.

## Interface
- NUM_PORTS, 4: number of requester ports; power of 2, 2..16; ID width IDW = log2(NUM_PORTS)
- DATA_W, 32: result data width
- DEPTH, 4: entries per port FIFO; power of 2, >= 2
- ERR_ON_OVF, 0: 1 = alu_overflow also forces an error response
- c_clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- prio_alu_out_vld  in  1  result valid this cycle
- prio_alu_out_req_id  in  [0:IDW-1]  destination port
- alu_result  in  [0:2*DATA_W-1]  data = bits [DATA_W:2*DATA_W-1]; error flag = bit [DATA_W-1]
- alu_overflow  in  1  ALU overflow for this result
- local_error_found  in  1  error qualifier for this result
- out_ack  in  [0:NUM_PORTS-1]  requester p consumes its head entry
- out_resp  out  [0:2*NUM_PORTS-1]  port p at [2p:2p+1]; 00 = none
- out_data  out  [0:NUM_PORTS*DATA_W-1]  port p at [p*DATA_W:p*DATA_W+DATA_W-1]
- port_full  out  [0:NUM_PORTS-1]  registered; port p FIFO holds DEPTH entries
- drop_pulse  out  1  registered; one-cycle pulse when a valid result was discarded

## Operation
- Response classification, computed at push time:
  - resp = 10 when local_error_found && (alu_result[DATA_W-1] || (ERR_ON_OVF && alu_overflow)).
  - Otherwise resp = 01.
  - 00 is never stored.
- Push condition: prio_alu_out_vld=1. The {resp, data} entry goes to the FIFO selected by prio_alu_out_req_id.
- Push acceptance: the push is accepted if count < DEPTH, or if the same port pops in the same cycle (count == DEPTH with out_ack asserted and resp nonzero).
- Drop: a push to a full port with no same-cycle pop is dropped. The FIFO is unchanged and drop_pulse = 1 on the next cycle.
- Pop condition: out_ack[p]=1 while port p is non-empty. out_ack on an empty port is ignored.
- Per-port state:
  - Storage array DEPTH x (2+DATA_W).
  - Read and write pointers, log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count, log2(DEPTH)+1 bits.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
- Outputs:
  - Port p shows its head entry when count > 0.
  - When count = 0, resp = 00 and data = 0.
  - Outputs depend only on registers; there is no combinational path from any input to any output.
- Ordering is FIFO per port. There is no ordering guarantee across ports.

## Timing
- Reset (reset = 0, asynchronous): all counts and pointers 0, out_resp = 0, out_data = 0, port_full = 0, drop_pulse = 0.
- Reset mid-operation discards all queued entries. The first edge after release behaves as idle.
- Push-to-visible latency is 1 cycle: a result pushed at edge N to an empty port appears on out_resp/out_data after edge N.
- Ack handshake:
  - The head entry is held stable until the edge where out_ack[p] = 1.
  - The next entry, or 00/0 if none, appears after that edge.
  - Back-to-back acks drain one entry per cycle.
- port_full:
  - Reflects the count after the current edge.
  - Upstream must use it one cycle ahead. Violations are handled by the drop rule, never by corruption.
- Pointer wrap: after DEPTH pushes and pops the pointers return to 0 with no gap or duplicate.

## Test plan
- Reset, then idle: all out_resp = 00, out_data = 0, port_full = 0 during and after reset.
- Single push, id=2, local_error_found=1, alu_result = {32'h0000_0001, 32'hDEAD_BEEF}:
  - Port 2 resp = 10, data = DEADBEEF one cycle later.
  - Held until out_ack[2], then 00/0.
- Fill port 0 with 4 pushes of data 1..4, no ack:
  - port_full[0] = 1.
  - A fifth push gives drop_pulse = 1 next cycle.
  - Acks then return 1, 2, 3, 4 in order.
- Port 1 full, same cycle push of data 9 plus out_ack[1]:
  - Push accepted, no drop, port_full[1] stays 1.
  - 9 appears last after draining.
- ERR_ON_OVF = 1, alu_overflow = 1, local_error_found = 1, error bit 0 -> resp 10. With ERR_ON_OVF = 0 the same stimulus gives resp 01.
- Interleaved pushes to all 4 ports, random acks for 1000 cycles, reset asserted mid-run:
  - Per-port order is preserved.
  - All ports read 00/0 immediately on reset assertion.

Source files
------------

// File: rtl/alu_output_router.sv
// ALU result router: classifies each prioritised result into a 2-bit response
// and queues {resp, data} in a per-requester FIFO that is held until acknowledged.
module alu_output_router #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int ERR_ON_OVF = 0,
    localparam int IDW       = $clog2(NUM_PORTS)
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic                        prio_alu_out_vld,
    input  logic [0:IDW-1]              prio_alu_out_req_id,
    input  logic [0:2*DATA_W-1]         alu_result,
    input  logic                        alu_overflow,
    input  logic                        local_error_found,
    input  logic [0:NUM_PORTS-1]        out_ack,
    output logic [0:2*NUM_PORTS-1]      out_resp,
    output logic [0:NUM_PORTS*DATA_W-1] out_data,
    output logic [0:NUM_PORTS-1]        port_full,
    output logic                        drop_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 2;

    typedef logic [EW-1:0] entry_t;

    entry_t               mem      [NUM_PORTS][DEPTH];
    logic [AW-1:0]        rd_ptr   [NUM_PORTS];
    logic [AW-1:0]        wr_ptr   [NUM_PORTS];
    logic [CW-1:0]        cnt      [NUM_PORTS];
    logic [CW-1:0]        cnt_next [NUM_PORTS];
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] accept;
    logic [1:0]           resp_cls;
    entry_t               push_entry;
    entry_t               head;
    logic                 drop_next;
    logic                 unused_result_bits;

    // Only the error flag and the data half of alu_result carry meaning.
    assign unused_result_bits = ^alu_result[0:DATA_W-2];

    always_comb begin
        resp_cls   = (local_error_found &&
                      (alu_result[DATA_W-1] || ((ERR_ON_OVF != 0) && alu_overflow)))
                     ? 2'b10 : 2'b01;
        push_entry = {resp_cls, alu_result[DATA_W +: DATA_W]};
        push       = '0;
        pop        = '0;
        accept     = '0;
        cnt_next   = cnt;
        drop_next  = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            push[p]   = prio_alu_out_vld && (prio_alu_out_req_id == IDW'(p));
            pop[p]    = out_ack[p] && (cnt[p] != '0);
            // A full port still accepts when its head leaves on the same edge.
            accept[p] = push[p] && ((cnt[p] != CW'(DEPTH)) || pop[p]);
            if (push[p] && !accept[p]) begin
                drop_next = 1'b1;
            end
            cnt_next[p] = cnt[p] + CW'(accept[p]) - CW'(pop[p]);
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                cnt[p]    <= '0;
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    mem[p][d] <= '0;
                end
            end
            port_full  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + AW'(1);
                end
                if (accept[p]) begin
                    mem[p][wr_ptr[p]] <= push_entry;
                    wr_ptr[p]         <= wr_ptr[p] + AW'(1);
                end
                cnt[p]       <= cnt_next[p];
                port_full[p] <= (cnt_next[p] == CW'(DEPTH));
            end
            drop_pulse <= drop_next;
        end
    end

    always_comb begin
        out_resp = '0;
        out_data = '0;
        head     = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (cnt[p] != '0) begin
                head                          = mem[p][rd_ptr[p]];
                out_resp[2*p +: 2]            = head[EW-1 -: 2];
                out_data[p*DATA_W +: DATA_W]  = head[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_output_router.sv
// Directed and randomized bench for alu_output_router against a queue-based
// reference model of the per-port FIFOs.
module tb_alu_output_router;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int DEP = 4;

    logic          c_clk = 1'b0;
    logic          reset;
    logic          prio_alu_out_vld;
    logic [0:1]    prio_alu_out_req_id;
    logic [0:63]   alu_result;
    logic          alu_overflow;
    logic          local_error_found;
    logic [0:3]    out_ack;

    logic [0:7]    o_resp, v_resp;
    logic [0:127]  o_data, v_data;
    logic [0:3]    o_full, v_full;
    logic          o_drop, v_drop;

    logic [33:0]   q [NP][$];
    logic          m_drop;
    logic          m_err;
    logic [31:0]   m_data;
    logic [30:0]   m_junk;
    int            checks = 0;
    int            errors = 0;

    alu_output_router #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEP), .ERR_ON_OVF(0)) dut (
        .c_clk(c_clk), .reset(reset), .prio_alu_out_vld(prio_alu_out_vld),
        .prio_alu_out_req_id(prio_alu_out_req_id), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .local_error_found(local_error_found),
        .out_ack(out_ack), .out_resp(o_resp), .out_data(o_data),
        .port_full(o_full), .drop_pulse(o_drop)
    );

    alu_output_router #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEP), .ERR_ON_OVF(1)) dut_ovf (
        .c_clk(c_clk), .reset(reset), .prio_alu_out_vld(prio_alu_out_vld),
        .prio_alu_out_req_id(prio_alu_out_req_id), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .local_error_found(local_error_found),
        .out_ack(out_ack), .out_resp(v_resp), .out_data(v_data),
        .port_full(v_full), .drop_pulse(v_drop)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [0:7]   e_resp;
        logic [0:127] e_data;
        logic [0:3]   e_full;
        e_resp = '0;
        e_data = '0;
        e_full = '0;
        for (int p = 0; p < NP; p++) begin
            if (q[p].size() > 0) begin
                e_resp[2*p +: 2]  = q[p][0][33:32];
                e_data[p*32 +: 32] = q[p][0][31:0];
            end
            e_full[p] = (q[p].size() == DEP);
        end
        chk("resp", o_resp, e_resp);
        chk("data", o_data, e_data);
        chk("full", o_full, e_full);
        chk("drop", o_drop, m_drop);
    endtask

    // Advance the model by one clock using the currently driven inputs, then compare.
    task automatic step();
        int id;
        for (int p = 0; p < NP; p++) begin
            if (out_ack[p] && q[p].size() > 0) void'(q[p].pop_front());
        end
        m_drop = 1'b0;
        if (prio_alu_out_vld) begin
            id = int'(prio_alu_out_req_id);
            if (q[id].size() < DEP)
                q[id].push_back({(local_error_found && m_err) ? 2'b10 : 2'b01, m_data});
            else
                m_drop = 1'b1;
        end
        @(posedge c_clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        prio_alu_out_vld = 1'b0;
        out_ack          = '0;
    endtask

    task automatic push_word(input int id, input logic [31:0] d);
        prio_alu_out_vld    = 1'b1;
        prio_alu_out_req_id = 2'(id);
        local_error_found   = 1'b0;
        m_err               = 1'b0;
        m_data              = d;
        alu_result          = {32'h0, d};
    endtask

    initial begin
        reset = 1'b0;
        idle();
        prio_alu_out_req_id = '0;
        alu_result          = '0;
        alu_overflow        = 1'b0;
        local_error_found   = 1'b0;
        m_err = 1'b0; m_data = '0; m_junk = '0; m_drop = 1'b0;

        // Reset and idle
        #1;
        chk("rst_resp", o_resp, 0);
        chk("rst_data", o_data, 0);
        chk("rst_full", o_full, 0);
        chk("rst_drop", o_drop, 0);
        repeat (2) @(posedge c_clk);
        #1;
        check_all();
        @(negedge c_clk) reset = 1'b1;
        step();

        // Overflow qualifies an error only when ERR_ON_OVF is set
        prio_alu_out_vld = 1'b1; prio_alu_out_req_id = 2'd3;
        local_error_found = 1'b1; alu_overflow = 1'b1;
        m_err = 1'b0; m_data = 32'h0000_A5A5; alu_result = {32'h0, 32'h0000_A5A5};
        step();
        chk("ovf_on_resp", v_resp[6:7], 2'b10);
        chk("ovf_off_resp", o_resp[6:7], 2'b01);
        idle(); alu_overflow = 1'b0; out_ack[3] = 1'b1;
        step();
        out_ack = '0;

        // Single push to port 2, held until acknowledged
        prio_alu_out_vld = 1'b1; prio_alu_out_req_id = 2'd2; local_error_found = 1'b1;
        alu_result = {32'h0000_0001, 32'hDEAD_BEEF}; m_err = 1'b1; m_data = 32'hDEAD_BEEF;
        step();
        idle();
        chk("p2_resp", o_resp[4:5], 2'b10);
        chk("p2_data", o_data[64:95], 32'hDEAD_BEEF);
        step();
        step();
        chk("p2_hold", o_data[64:95], 32'hDEAD_BEEF);
        out_ack[2] = 1'b1;
        step();
        idle();
        chk("p2_gone_resp", o_resp[4:5], 2'b00);
        chk("p2_gone_data", o_data[64:95], 32'h0);

        // Fill port 0, overflow it, then drain in order
        for (int i = 1; i <= 4; i++) begin
            push_word(0, 32'(i));
            step();
        end
        chk("p0_full", o_full[0], 1'b1);
        push_word(0, 32'd5);
        step();
        idle();
        chk("p0_drop", o_drop, 1'b1);
        step();
        chk("p0_drop_clear", o_drop, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("p0_order", o_data[0:31], 32'(i));
            out_ack[0] = 1'b1;
            step();
            out_ack = '0;
        end
        chk("p0_empty", o_resp[0:1], 2'b00);
        chk("p0_not_full", o_full[0], 1'b0);

        // Full port with same-cycle pop accepts the push
        for (int i = 5; i <= 8; i++) begin
            push_word(1, 32'(i));
            step();
        end
        push_word(1, 32'd9);
        out_ack[1] = 1'b1;
        step();
        idle();
        chk("p1_no_drop", o_drop, 1'b0);
        chk("p1_still_full", o_full[1], 1'b1);
        for (int i = 6; i <= 9; i++) begin
            chk("p1_order", o_data[32:63], 32'(i));
            out_ack[1] = 1'b1;
            step();
            out_ack = '0;
        end
        chk("p1_empty", o_data[32:63], 32'h0);

        // Random traffic with a reset in the middle
        for (int c = 0; c < 1000; c++) begin
            prio_alu_out_vld    = ($urandom_range(0, 3) != 0);
            prio_alu_out_req_id = 2'($urandom_range(0, 3));
            local_error_found   = 1'($urandom_range(0, 1));
            alu_overflow        = 1'($urandom_range(0, 1));
            m_err               = 1'($urandom_range(0, 1));
            m_data              = $urandom;
            m_junk              = 31'($urandom);
            alu_result          = {m_junk, m_err, m_data};
            for (int p = 0; p < NP; p++) out_ack[p] = ($urandom_range(0, 3) == 0);
            step();
            if (c == 500) begin
                idle();
                #2 reset = 1'b0;
                #1;
                for (int p = 0; p < NP; p++) q[p].delete();
                m_drop = 1'b0;
                chk("midrst_resp", o_resp, 0);
                chk("midrst_data", o_data, 0);
                chk("midrst_full", o_full, 0);
                chk("midrst_drop", o_drop, 0);
                step();
                step();
                @(negedge c_clk) reset = 1'b1;
            end
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
